// File: rtl/pll_lock_reset_gen_if.sv
// Lock/reset and drum timing signal bundle.
// master drives lock, transport and tempo; slave returns reset and strobes.
interface pll_lock_reset_gen_if;
    logic       pll_lock;
    logic       run;
    logic [7:0] bpm;
    logic       sys_rst_n;
    logic       sample_tick;
    logic       step_tick;
    logic [3:0] step_idx;

    modport master (
        output pll_lock, run, bpm,
        input  sys_rst_n, sample_tick, step_tick, step_idx
    );

    modport slave (
        input  pll_lock, run, bpm,
        output sys_rst_n, sample_tick, step_tick, step_idx
    );
endinterface

// File: rtl/pll_lock_reset_gen.sv
// PLL lock qualifier, system reset release and drum machine timing.
// Produces the audio sample strobe and a drift-free 16th-note step strobe.
module pll_lock_reset_gen #(
    parameter int CLK_HZ      = 150_000_000,
    parameter int SAMPLE_HZ   = 48_000,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int BPM_MIN     = 40,
    parameter int BPM_MAX     = 250
) (
    input logic           clk,
    input logic           rst_n,
    pll_lock_reset_gen_if.slave bus
);

    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int ACC_W = 22;
    localparam int SUM_W = ACC_W + 1;
    localparam int LIMIT = SAMPLE_HZ * 60;

    localparam logic [7:0]       BMIN  = 8'(BPM_MIN);
    localparam logic [7:0]       BMAX  = 8'(BPM_MAX);
    localparam logic [SUM_W-1:0] LIM_S = SUM_W'(LIMIT);

    generate
        if (CLK_HZ % SAMPLE_HZ != 0) begin : g_bad_div
            $error("CLK_HZ must be a multiple of SAMPLE_HZ");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
        if (LIMIT >= (1 << ACC_W)) begin : g_bad_lim
            $error("SAMPLE_HZ*60 does not fit the accumulator");
        end
    endgenerate

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABILIZE,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [SYNC_STAGES-1:0]  sync;
    logic                    lock_s;
    logic [LCK_W-1:0]        lock_cnt;
    logic [DIV_W-1:0]        div_cnt;
    logic                    rst_q;
    logic                    run_nx;
    logic                    keep;
    logic                    tick;
    logic                    step;
    logic [7:0]              bpm_c;
    logic [SUM_W-1:0]        sum;
    logic                    wrap;
    logic [ACC_W-1:0]        acc;
    logic                    first;
    logic [3:0]              idx;

    always_ff @(posedge clk) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], bus.pll_lock};
    end

    assign lock_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= WAIT_LOCK;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            WAIT_LOCK: if (lock_s) state_nx = STABILIZE;
            STABILIZE: begin
                if (!lock_s)
                    state_nx = WAIT_LOCK;
                else if (lock_cnt == LCK_W'(LOCK_CYCLES - 1))
                    state_nx = RUN;
            end
            RUN:       if (!lock_s) state_nx = WAIT_LOCK;
            default:   state_nx = WAIT_LOCK;
        endcase
    end

    always_comb begin
        run_nx = (state_nx == RUN);
        keep   = run_nx && bus.run;
        tick   = (state == RUN) && (div_cnt == DIV_W'(DIV - 1));
        bpm_c  = bus.bpm;
        if (bus.bpm < BMIN) bpm_c = BMIN;
        if (bus.bpm > BMAX) bpm_c = BMAX;
        sum    = {1'b0, acc} + SUM_W'({bpm_c, 2'b00});
        wrap   = (sum >= LIM_S);
        step   = tick && bus.run && (first || wrap);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state != STABILIZE) lock_cnt <= '0;
        else                              lock_cnt <= lock_cnt + LCK_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rst_q <= 1'b0;
        else        rst_q <= run_nx;
    end

    // counter clears on the same edge RUN is left, so ticks stop with sys_rst_n
    always_ff @(posedge clk) begin
        if (!rst_n || !run_nx || state != RUN)
            div_cnt <= '0;
        else if (div_cnt == DIV_W'(DIV - 1))
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !keep) begin
            acc   <= '0;
            idx   <= '0;
            first <= 1'b1;
        end else if (tick) begin
            if (first) begin
                first <= 1'b0;
                acc   <= '0;
            end else if (wrap) begin
                acc <= ACC_W'(sum - LIM_S);
                idx <= idx + 4'd1;
            end else begin
                acc <= ACC_W'(sum);
            end
        end
    end

    assign bus.sys_rst_n   = rst_q;
    assign bus.sample_tick = tick;
    assign bus.step_tick   = step;
    assign bus.step_idx    = idx;

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// Scoreboard bench for pll_lock_reset_gen.
// Uses a reduced sample rate (DIV=10, LIMIT=28800) so whole step cycles fit.
module tb_pll_lock_reset_gen;

    localparam int DIV = 10;
    localparam int SHZ = 480;
    localparam int L   = SHZ * 60;

    typedef struct {
        int smp;
        int idx;
    } step_t;

    logic clk;
    logic rst_n;
    pll_lock_reset_gen_if bus ();

    pll_lock_reset_gen #(
        .CLK_HZ     (SHZ * DIV),
        .SAMPLE_HZ  (SHZ),
        .SYNC_STAGES(2),
        .LOCK_CYCLES(8),
        .BPM_MIN    (40),
        .BPM_MAX    (250)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int    errors = 0;
    int    checks = 0;
    step_t sb[$];
    step_t mon_e;
    int    rcyc = 0;
    int    smp = 0;
    bit    mon_en = 0;
    bit    idx_due = 0;
    int    exp_idx = 0;
    bit    exp_s;
    bit    exp_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int inc_of(input int b);
        int c;
        c = (b < 40) ? 40 : ((b > 250) ? 250 : b);
        return 4 * c;
    endfunction

    // step k lands on the first sample where acc0 + r*inc reaches k*L
    task automatic push_sched(input int base, input int acc0, input int inc,
                              input int idx0, input int n, output int last);
        step_t e;
        last = base;
        for (int k = 1; k <= n; k++) begin
            e.smp = base + (k * L - acc0 + inc - 1) / inc;
            e.idx = (idx0 + k) % 16;
            sb.push_back(e);
            last = e.smp;
        end
    endtask

    task automatic wait_smp(input int target);
        int n;
        n = 0;
        while (smp < target && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (smp < target) chk("wait_smp", 32'(smp), 32'(target));
        #2;
    endtask

    task automatic wait_release(input string tag, input int want);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.sys_rst_n && k < 40);
        chk(tag, 32'(k), 32'(want));
    endtask

    task automatic start_run(input int b, input int n, output int last);
        step_t e;
        bus.run = 1'b0;
        @(posedge clk);
        #2;
        bus.bpm = 8'(b);
        bus.run = 1'b1;
        chk("sb_empty", 32'(sb.size()), 0);
        e.smp = smp + 1;
        e.idx = 0;
        sb.push_back(e);
        push_sched(e.smp, 0, inc_of(b), 0, n, last);
    endtask

    always @(negedge clk) begin
        if (idx_due) begin
            chk("step_idx", 32'(bus.step_idx), 32'(exp_idx));
            idx_due = 0;
        end
        if (mon_en) begin
            rcyc++;
            exp_s = (rcyc % DIV == 0);
            if (exp_s) smp++;
            exp_t = exp_s && sb.size() > 0 && sb[0].smp == smp;
            chk("sample_tick", 32'(bus.sample_tick), 32'(exp_s));
            chk("step_tick", 32'(bus.step_tick), 32'(exp_t));
            if (exp_t) begin
                mon_e   = sb.pop_front();
                exp_idx = mon_e.idx;
                idx_due = 1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    last;
        int    f;
        int    c;
        logic  early;
        logic  bad;
        step_t e;

        rst_n        = 1'b0;
        bus.pll_lock = 1'b1;
        bus.run      = 1'b0;
        bus.bpm      = 8'd120;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_sys_rst_n", 32'(bus.sys_rst_n), 0);
        chk("rst_sample_tick", 32'(bus.sample_tick), 0);
        chk("rst_step_tick", 32'(bus.step_tick), 0);
        chk("rst_step_idx", 32'(bus.step_idx), 0);
        rst_n = 1'b1;
        wait_release("release_edges", 11);

        rcyc   = 0;
        smp    = 0;
        mon_en = 1;
        wait_smp(2);

        // 120 bpm: 60 samples per step, through a wrap of the index
        start_run(120, 18, last);
        wait_smp(last + 5);
        bus.run = 1'b0;
        @(posedge clk);
        #1;
        chk("idx_clear", 32'(bus.step_idx), 0);
        bus.run = 1'b1;
        f       = smp + 1;
        e.smp   = f;
        e.idx   = 0;
        sb.push_back(e);
        push_sched(f, 0, inc_of(120), 0, 2, last);

        // tempo change mid-step keeps the accumulator phase
        c = f + 150;
        wait_smp(c);
        bus.bpm = 8'd121;
        push_sched(c, (150 * 480) % L, inc_of(121), (150 * 480) / L, 4, last);
        wait_smp(last);

        start_run(0, 3, last);
        wait_smp(last);
        start_run(255, 6, last);
        wait_smp(last);
        chk("sb_drained", 32'(sb.size()), 0);

        // lock loss while running
        @(posedge clk);
        #2;
        mon_en       = 0;
        bus.pll_lock = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk((k < 3) ? "loss_hold" : "loss_fall",
                32'(bus.sys_rst_n), (k < 3) ? 32'd1 : 32'd0);
        end
        chk("loss_step_idx", 32'(bus.step_idx), 0);
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            bad = bad | bus.sample_tick | bus.step_tick
                | bus.sys_rst_n | (bus.step_idx != 4'd0);
        end
        chk("loss_quiet", 32'(bad), 0);

        // one-cycle lock glitch during stabilisation
        bus.run      = 1'b0;
        bus.pll_lock = 1'b1;
        early        = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            early = early | bus.sys_rst_n;
            if (k == 7) bus.pll_lock = 1'b0;
            if (k == 8) bus.pll_lock = 1'b1;
        end
        chk("glitch_hold", 32'(early), 0);
        wait_release("glitch_release", 11);

        rcyc   = 0;
        smp    = 0;
        mon_en = 1;
        wait_smp(3);

        // reset while running drops everything on the next edge
        @(posedge clk);
        #2;
        mon_en  = 0;
        bus.run = 1'b1;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_sys_rst_n", 32'(bus.sys_rst_n), 0);
        chk("mid_rst_sample_tick", 32'(bus.sample_tick), 0);
        chk("mid_rst_step_tick", 32'(bus.step_tick), 0);
        chk("mid_rst_step_idx", 32'(bus.step_idx), 0);
        chk("sb_final", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
